// File: rtl/spi_sram_pkg.sv
// Shared constants and types for the SPI serial-SRAM Wishbone responder.
// Optional feature macro: SPI_SRAM_SEQ_READ_EN (sequential-read HOLD mode).
package spi_sram_pkg;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRITE = 8'h02;

    localparam int unsigned CMD_BITS  = 8;
    localparam int unsigned DATA_BITS = 8;

    // Idle clocks spent in HOLD before chip select is released
    localparam int unsigned HOLD_TIMEOUT = 64;
    localparam int unsigned HOLD_CNT_W   = $clog2(HOLD_TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // Total bits in a full command frame: opcode + address + data
    function automatic int unsigned frame_bits(input int unsigned addr_bits);
        return CMD_BITS + addr_bits + DATA_BITS;
    endfunction

endpackage

// File: rtl/spi_sram_shifter.sv
// SPI mode-0 bit engine: parallel load, MSB-first transmit, 8-bit receive,
// SCK at clk/2, and a combinational done flag on the edge that ends the last bit.
module spi_sram_shifter #(
    parameter int unsigned WIDTH = 40,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic [CNT_W-1:0] last_bit,
    input  logic             miso,
    output logic             sck,
    output logic             mosi,
    output logic [7:0]       rx_byte,
    output logic             done
);

    logic [WIDTH-1:0] sh;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] last;
    logic             busy;
    logic [7:0]       rx;

    // Shift engine: rising SCK on odd edges, falling SCK + sample/advance on even edges
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sh   <= '0;
            cnt  <= '0;
            last <= '0;
            busy <= 1'b0;
            sck  <= 1'b0;
            rx   <= '0;
        end else if (load) begin
            sh   <= load_data;
            cnt  <= '0;
            last <= last_bit;
            busy <= 1'b1;
            sck  <= 1'b0;
        end else if (busy) begin
            if (!sck) begin
                sck <= 1'b1;
            end else begin
                sck <= 1'b0;
                rx  <= {rx[6:0], miso};
                if (cnt == last) begin
                    busy <= 1'b0;
                    sh   <= '0;
                end else begin
                    sh  <= {sh[WIDTH-2:0], 1'b0};
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

    assign mosi    = sh[WIDTH-1];
    // Final MISO bit is folded in so the caller can capture the byte on the done edge
    assign rx_byte = {rx[6:0], miso};
    assign done    = busy & sck & (cnt == last);

endmodule

// File: rtl/spi_sram_wb_responder.sv
// Wishbone byte responder backed by an SPI mode-0 serial SRAM.
// Each access becomes one opcode/address/data frame; with SPI_SRAM_SEQ_READ_EN
// defined, chip select is held after a read so an incrementing read streams
// only the next data byte.
module spi_sram_wb_responder
    import spi_sram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH    = 24,
    parameter int unsigned SPI_ADDR_BITS = 24
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wbs_cyc_i,
    input  logic                  wbs_stb_i,
    input  logic [ADDR_WIDTH-1:0] wbs_adr_i,
    input  logic                  wbs_we_i,
    input  logic [7:0]            wbs_dat_i,
    output logic                  wbs_ack_o,
    output logic                  wbs_err_o,
    output logic                  wbs_rty_o,
    output logic [7:0]            wbs_dat_o,
    output logic                  spi_cs_n_o,
    output logic                  spi_sck_o,
    output logic                  spi_mosi_o,
    input  logic                  spi_miso_i
);

    localparam int unsigned FRAME_BITS = frame_bits(SPI_ADDR_BITS);
    localparam int unsigned CNT_W      = $clog2(FRAME_BITS);

    state_t                  state;
    logic                    req;
    logic                    is_read;
    logic                    sh_load;
    logic [FRAME_BITS-1:0]   sh_data;
    logic [CNT_W-1:0]        sh_last;
    logic [7:0]              sh_rx;
    logic                    sh_done;

`ifdef SPI_SRAM_SEQ_READ_EN
    logic [SPI_ADDR_BITS-1:0] last_adr;
    logic [SPI_ADDR_BITS-1:0] next_adr;
    logic [HOLD_CNT_W-1:0]    hold_cnt;
    logic                     cont_hit;

    assign next_adr = last_adr + SPI_ADDR_BITS'(1);
    assign cont_hit = !wbs_we_i && (wbs_adr_i[SPI_ADDR_BITS-1:0] == next_adr);
`endif

    assign wbs_err_o = 1'b0;
    assign wbs_rty_o = 1'b0;

    // The !ack gate keeps a request still asserted during ack from being taken twice
    assign req = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;

    // Shifter load selection: full frame from IDLE, data-only frame for a continuation
    always_comb begin
        sh_load = 1'b0;
        sh_data = '0;
        sh_last = CNT_W'(FRAME_BITS - 1);
        if (state == ST_IDLE && req) begin
            sh_load = 1'b1;
            sh_data = {(wbs_we_i ? CMD_WRITE : CMD_READ),
                       wbs_adr_i[SPI_ADDR_BITS-1:0],
                       (wbs_we_i ? wbs_dat_i : 8'h00)};
        end
`ifdef SPI_SRAM_SEQ_READ_EN
        if (state == ST_HOLD && req && cont_hit) begin
            sh_load = 1'b1;
            sh_data = '0;
            sh_last = CNT_W'(DATA_BITS - 1);
        end
`endif
    end

    spi_sram_shifter #(
        .WIDTH (FRAME_BITS),
        .CNT_W (CNT_W)
    ) u_shifter (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load      (sh_load),
        .load_data (sh_data),
        .last_bit  (sh_last),
        .miso      (spi_miso_i),
        .sck       (spi_sck_o),
        .mosi      (spi_mosi_o),
        .rx_byte   (sh_rx),
        .done      (sh_done)
    );

    // Wishbone handshake and transaction sequencing
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            spi_cs_n_o <= 1'b1;
            wbs_ack_o  <= 1'b0;
            wbs_dat_o  <= 8'h00;
            is_read    <= 1'b0;
`ifdef SPI_SRAM_SEQ_READ_EN
            last_adr   <= '0;
            hold_cnt   <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    wbs_ack_o <= 1'b0;
                    if (req) begin
                        spi_cs_n_o <= 1'b0;
                        is_read    <= ~wbs_we_i;
                        state      <= ST_SHIFT;
`ifdef SPI_SRAM_SEQ_READ_EN
                        last_adr   <= wbs_adr_i[SPI_ADDR_BITS-1:0];
`endif
                    end
                end
                ST_SHIFT: begin
                    if (sh_done) begin
                        // A master that abandoned the cycle gets no ack, but the frame still completes
                        wbs_ack_o <= wbs_cyc_i & wbs_stb_i;
                        if (is_read) begin
                            wbs_dat_o <= sh_rx;
                        end
`ifdef SPI_SRAM_SEQ_READ_EN
                        spi_cs_n_o <= ~(is_read & wbs_cyc_i & wbs_stb_i);
`else
                        spi_cs_n_o <= 1'b1;
`endif
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    wbs_ack_o <= 1'b0;
`ifdef SPI_SRAM_SEQ_READ_EN
                    hold_cnt <= '0;
                    state    <= spi_cs_n_o ? ST_IDLE : ST_HOLD;
`else
                    state    <= ST_IDLE;
`endif
                end
`ifdef SPI_SRAM_SEQ_READ_EN
                ST_HOLD: begin
                    if (req) begin
                        if (cont_hit) begin
                            last_adr <= wbs_adr_i[SPI_ADDR_BITS-1:0];
                            state    <= ST_SHIFT;
                        end else begin
                            // Release CS for a clock; IDLE then starts a full frame
                            spi_cs_n_o <= 1'b1;
                            state      <= ST_IDLE;
                        end
                    end else if (hold_cnt == HOLD_CNT_W'(HOLD_TIMEOUT - 1)) begin
                        spi_cs_n_o <= 1'b1;
                        state      <= ST_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_CNT_W'(1);
                    end
                end
`endif
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_sram_wb_responder.sv
// Scoreboard bench for spi_sram_wb_responder with a behavioural serial-SRAM device.
module tb_spi_sram_wb_responder;
    import spi_sram_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
    logic [23:0] wbs_adr_i = '0;
    logic [7:0]  wbs_dat_i = '0;
    logic        wbs_ack_o, wbs_err_o, wbs_rty_o;
    logic [7:0]  wbs_dat_o;
    logic        spi_cs_n_o, spi_sck_o, spi_mosi_o;
    logic        spi_miso_i = 1'b0;

    always #5 clk = ~clk;

    spi_sram_wb_responder #(.ADDR_WIDTH(24), .SPI_ADDR_BITS(24)) dut (
        .clk_i(clk), .rst_i(rst),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_adr_i(wbs_adr_i),
        .wbs_we_i(wbs_we_i), .wbs_dat_i(wbs_dat_i), .wbs_ack_o(wbs_ack_o),
        .wbs_err_o(wbs_err_o), .wbs_rty_o(wbs_rty_o), .wbs_dat_o(wbs_dat_o),
        .spi_cs_n_o(spi_cs_n_o), .spi_sck_o(spi_sck_o), .spi_mosi_o(spi_mosi_o),
        .spi_miso_i(spi_miso_i)
    );

`ifdef SPI_SRAM_SEQ_READ_EN
    localparam bit SEQ = 1'b1;
`else
    localparam bit SEQ = 1'b0;
`endif

    int checks = 0;
    int failures = 0;
    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    function automatic logic [7:0] default_byte(input logic [23:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
    endfunction

    // ---------------- serial SRAM device ----------------
    logic [7:0]  sram_mem [logic [23:0]];
    int          nbits = 0;
    logic [31:0] in_sr = '0;
    logic [7:0]  frame_cmd = '0;
    logic [23:0] frame_adr = '0;

    function automatic logic [7:0] sram_rd(input logic [23:0] a);
        return sram_mem.exists(a) ? sram_mem[a] : default_byte(a);
    endfunction

    always @(negedge spi_cs_n_o) nbits = 0;

    always @(posedge spi_sck_o) begin
        if (spi_cs_n_o === 1'b0) begin
            in_sr = {in_sr[30:0], spi_mosi_o};
            nbits++;
            if (nbits == 8)  frame_cmd = in_sr[7:0];
            if (nbits == 32) frame_adr = in_sr[23:0];
            if (nbits >= 40 && nbits % 8 == 0 && frame_cmd == CMD_WRITE)
                sram_mem[frame_adr + 24'((nbits - 40) / 8)] = in_sr[7:0];
        end
    end

    always @(negedge spi_sck_o) begin
        if (spi_cs_n_o === 1'b0) begin
            #1;
            if (frame_cmd == CMD_READ && nbits >= 32) begin
                int idx;
                logic [7:0] b;
                idx = nbits - 32;
                b = sram_rd(frame_adr + 24'(idx / 8));
                spi_miso_i = b[7 - (idx % 8)];
            end
        end
    end

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        int          exp_cycle;
        logic [7:0]  exp_dat;
        bit          is_read;
        bit          cont;
        logic [23:0] adr;
        logic [7:0]  wdat;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  ref_mem [logic [23:0]];
    logic [7:0]  exp_dat_o = 8'h00;
    bit          hold_valid = 1'b0;
    logic [23:0] hold_adr = '0;

    function automatic logic [7:0] ref_rd(input logic [23:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : default_byte(a);
    endfunction

    // lead = clock edges that pass before the DUT can first sample the request
    task automatic issue(input logic we, input logic [23:0] adr, input logic [7:0] dat, input int lead);
        exp_t e;
        int lat;
        logic [23:0] nxt;
        nxt = hold_adr + 24'd1;
        lat = 80;
        e.cont = 1'b0;
        if (SEQ && hold_valid) begin
            if (!we && adr == nxt) begin lat = 16; e.cont = 1'b1; end
            else lat = 81;
        end
        if (we) ref_mem[adr] = dat;
        else    exp_dat_o = ref_rd(adr);
        hold_valid = SEQ && !we;
        hold_adr   = adr;
        e.exp_cycle = cyc_cnt + lead + 1 + lat;
        e.exp_dat   = exp_dat_o;
        e.is_read   = !we;
        e.adr       = adr;
        e.wdat      = dat;
        sb.push_back(e);
    endtask

    logic prev_ack = 1'b0;

    always @(negedge clk) begin
        if (wbs_ack_o === 1'b1) begin
            exp_t e;
            chk("ack_width", {31'd0, prev_ack}, 32'd0);
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ack actual=1 required=0 (cycle %0d)", cyc_cnt);
            end else begin
                e = sb.pop_front();
                chk("ack_latency", cyc_cnt, e.exp_cycle);
                chk(e.is_read ? "rd_data" : "wr_dat_o_kept", wbs_dat_o, e.exp_dat);
                if (!e.cont) begin
                    chk("mosi_cmd", frame_cmd, e.is_read ? CMD_READ : CMD_WRITE);
                    chk("mosi_adr", frame_adr, e.adr);
                end
                if (!e.is_read) chk("sram_wr", sram_rd(e.adr), e.wdat);
            end
        end
        prev_ack = wbs_ack_o;
    end

    // ---------------- stimulus ----------------
    task automatic wait_ack();
        int t = 0;
        while (wbs_ack_o !== 1'b1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) begin
            checks++;
            failures++;
            $display("FAIL ack_timeout actual=no_ack required=ack (cycle %0d)", cyc_cnt);
        end
    endtask

    task automatic drive(input logic we, input logic [23:0] adr, input logic [7:0] dat);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_adr_i = adr;  wbs_dat_i = dat;
        issue(we, adr, dat, 0);
        wait_ack();
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        logic [23:0] radr;
        logic [23:0] last;
        int t;
        sram_mem[24'h000123] = 8'hA5;
        ref_mem[24'h000123]  = 8'hA5;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_cs_n", spi_cs_n_o, 1);
        chk("rst_sck",  spi_sck_o, 0);
        chk("rst_mosi", spi_mosi_o, 0);
        chk("rst_ack",  wbs_ack_o, 0);
        chk("rst_dat",  wbs_dat_o, 8'h00);
        chk("err_tied", wbs_err_o, 0);
        chk("rty_tied", wbs_rty_o, 0);
        rst = 1'b0;
        @(negedge clk);

        // basic read and write
        drive(1'b0, 24'h000123, 8'h00);
`ifndef SPI_SRAM_SEQ_READ_EN
        chk("cs_high_after_rd", spi_cs_n_o, 1);
`endif
        drive(1'b1, 24'h800010, 8'h3C);
        chk("cs_high_after_wr", spi_cs_n_o, 1);

        // back-to-back with cyc/stb held
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 24'h000200;
        issue(1'b0, 24'h000200, 8'h00, 0);
        wait_ack();
        wbs_adr_i = 24'h000300;
        issue(1'b0, 24'h000300, 8'h00, 1);
        @(negedge clk);
`ifndef SPI_SRAM_SEQ_READ_EN
        chk("b2b_cs_gap", spi_cs_n_o, 1);
`endif
        wait_ack();
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        @(negedge clk);

        // reset in the middle of a read
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 24'h000040;
        repeat (30) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_cs_n", spi_cs_n_o, 1);
        chk("midrst_sck",  spi_sck_o, 0);
        chk("midrst_dat",  wbs_dat_o, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        exp_dat_o = 8'h00;
        hold_valid = 1'b0;
        @(negedge clk);
        drive(1'b0, 24'h000000, 8'h00);

        // master abandons a read mid-frame
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 24'h000077;
        exp_dat_o = ref_rd(24'h000077);
        hold_valid = 1'b0;
        repeat (40) @(negedge clk);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        t = 0;
        while (spi_cs_n_o !== 1'b1 && t < 100) begin @(negedge clk); t++; end
        chk("abandon_cs_release", {31'd0, spi_cs_n_o}, 32'd1);
        repeat (3) @(negedge clk);
        chk("abandon_dat", wbs_dat_o, exp_dat_o);
        drive(1'b0, 24'h000078, 8'h00);

`ifdef SPI_SRAM_SEQ_READ_EN
        // HOLD timeout after the last read
        repeat (58) @(negedge clk);
        chk("hold_cs_low", spi_cs_n_o, 0);
        repeat (10) @(negedge clk);
        chk("hold_timeout_cs", spi_cs_n_o, 1);
        hold_valid = 1'b0;
`endif
        // sequential-read pattern and address wrap
        drive(1'b0, 24'h800000, 8'h00);
        drive(1'b0, 24'h800001, 8'h00);
        drive(1'b0, 24'h000042, 8'h00);
        drive(1'b0, 24'hFFFFFF, 8'h00);
        drive(1'b0, 24'h000000, 8'h00);

        // randomized traffic in a small window to get read-after-write hits
        last = 24'h000000;
        for (int i = 0; i < 24; i++) begin
            logic we;
            we = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 1) == 1) radr = last + 24'd1;
            else radr = {($urandom_range(0, 1) == 1) ? 8'h80 : 8'h00, 8'h00, 8'($urandom_range(0, 31))};
            drive(we, radr, 8'($urandom));
            last = radr;
        end

        repeat (5) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_sram_wb_responder.md
Name: spi_sram_wb_responder

Overview:
- Wishbone slave (responder) serving byte reads/writes from the Levenshtein controller's Wishbone master.
- Covers the dictionary region and the bit-vector lookup region.
- Translates each Wishbone access into one SPI-mode-0 transaction on an external serial SRAM: opcode 0x03 read / 0x02 write, 24-bit address, 8 data bits.
- Sits between the controller's master port and the chip's SPI pins.

Parameters:
- ADDR_WIDTH, 24, Wishbone address width; equals the controller's MASTER_ADDR_WIDTH.
- SPI_ADDR_BITS, 24, number of address bits sent MSB-first on MOSI; sourced from wbs_adr_i[SPI_ADDR_BITS-1:0], upper bits ignored.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset; asynchronous, active-high
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_stb_i  in  1  Wishbone strobe
- wbs_adr_i  in  ADDR_WIDTH  byte address
- wbs_we_i  in  1  1 = write
- wbs_dat_i  in  8  write data
- wbs_ack_o  out  1  single-cycle acknowledge
- wbs_err_o  out  1  tied 0
- wbs_rty_o  out  1  tied 0
- wbs_dat_o  out  8  read data, registered
- spi_cs_n_o  out  1  SRAM chip select, active-low
- spi_sck_o  out  1  SPI clock, registered, mode 0
- spi_mosi_o  out  1  serial data to SRAM
- spi_miso_i  in  1  serial data from SRAM

Behaviour:
- Reset (async, any state): cs_n=1, sck=0, mosi=0, ack=0, dat_o=0x00, state IDLE. A reset mid-transaction aborts it; the raised CS terminates the SRAM command.
- States: IDLE, SHIFT, DONE.
- IDLE: request = cyc & stb & !ack.
- Edge E0 samples a request and loads a 40-bit (8+SPI_ADDR_BITS+8) shift register with {opcode, adr, we ? dat_i : 0x00}. The same edge sets cs_n=0, sck=0, mosi=MSB, bit counter=0.
- SHIFT, odd edges: sck<=1.
- SHIFT, even edges: sck<=0, miso shifted into the receive register, mosi<=next bit, counter+1.
- SCK runs at clk/2. MOSI is stable for a full SCK-high phase. MISO is sampled on the edge that lowers SCK.
- E80 (last bit): sck=0, cs_n=1, state DONE. wbs_ack_o<=1 only if cyc&stb are still high; else no ack.
- E80, read: wbs_dat_o<=received byte.
- E80, write: wbs_dat_o unchanged.
- Latency: ack is high during the cycle after E80, i.e. 80 clocks after E0. Ack is high for exactly one cycle.
- DONE → IDLE after one clock (ack cleared). CS is high for at least 1 clock between transactions.
- A new request in the cycle ack is high is ignored (the !ack gate); it is taken on the following edge.
- wbs_adr_i/we/dat_i are captured at E0. Changes afterwards have no effect.
- Counter width is derived from the total bit count; no wrap beyond the final bit.

Optional Feature:
- Macro: SPI_SRAM_SEQ_READ_EN.
- Defined: after a read ack, CS stays low in state HOLD (sck=0). The next request is a continuation if it is a read with adr == last_adr+1 (mod 2^SPI_ADDR_BITS).
  - Continuation: shifts 8 data bits only, no opcode/address; ack after 16 clocks.
  - Any other request: cs_n=1 for one clock, then a full 80-clock transaction.
  - HOLD with no request for 64 clocks: cs_n=1, go to IDLE.
- Undefined: every access is a full transaction; no HOLD state.

Decomposition:
- Package spi_sram_pkg holds:
  - CMD_READ=8'h03, CMD_WRITE=8'h02
  - the state enum (IDLE, SHIFT, DONE, HOLD)
  - bit-count localparams
  - HOLD_TIMEOUT=64
- One sub-module: spi_sram_shifter (parallel load, N-bit MSB-first TX/RX, sck generation, done pulse). The top level owns the Wishbone handshake and sequencing.

Test Plan:
- Read adr 0x000123, SRAM model returns 0xA5 → MOSI carries 0x03,0x00,0x01,0x23; wbs_dat_o=0xA5; ack one cycle exactly 80 clocks after E0; cs_n high after.
- Write adr 0x800010, dat 0x3C → MOSI carries 0x02,0x80,0x00,0x10,0x3C; model memory holds 0x3C; wbs_dat_o unchanged; ack at 80 clocks.
- Back-to-back reads with cyc/stb held high → second transaction starts only after ack falls; cs_n high ≥1 clock between; no duplicate ack.
- rst_i pulsed at clock 30 of a read → cs_n=1, sck=0, ack never asserted. Next read of 0x000000 returns the model byte correctly.
- cyc dropped at clock 40 of a read → SPI sequence completes; no ack issued; next request served normally.
- SPI_SRAM_SEQ_READ_EN: reads 0x800000, 0x800001, then 0x000042 → ack latencies 80, 16, 81 (1-clock CS-high gap plus 80); data matches model.
